// File: rtl/note_recorder_if.sv
// note_recorder_if: this interface bundles the keyboard-side and status signals
// of note_recorder.
//   master modport: the driver side (the key scanner and the command source).
//   slave modport:  the note_recorder itself.
//   key_valid / key_in          held key and its code (0..47)
//   rec_start/play_start/stop   single-cycle command pulses
//   key_encoded                 note code to the decoder (63 = rest)
//   state                       0=IDLE 1=REC 2=PLAY
//   full / length               recording truncated / stored entry count
interface note_recorder_if #(
    parameter int DEPTH = 64
);
    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic             key_valid;
    logic [5:0]       key_in;
    logic             rec_start;
    logic             play_start;
    logic             stop;
    logic [5:0]       key_encoded;
    logic [1:0]       state;
    logic             full;
    logic [LEN_W-1:0] length;

    modport master (
        output key_valid, key_in, rec_start, play_start, stop,
        input  key_encoded, state, full, length
    );

    modport slave (
        input  key_valid, key_in, rec_start, play_start, stop,
        output key_encoded, state, full, length
    );
endinterface

// File: rtl/note_recorder.sv
// note_recorder: this block records held keys as run-length {note, duration} entries
// and plays them back.
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    note_recorder_if.slave (keys, commands, key_encoded, state, full, length)
// Parameters: DEPTH (entries, power of two 4..256) and TICK_DIV (clk cycles per tick).
// Optional feature: define NOTE_REC_LOOP_EN so that playback loops back to entry 0
// until stop is pulsed. In the default build, playback runs once.
module note_recorder #(
    parameter int DEPTH    = 64,
    parameter int TICK_DIV = 500000
) (
    input logic            clk,
    input logic            rst_n,
    note_recorder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam logic [5:0] REST = 6'd63;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REC = 2'd1, S_PLAY = 2'd2} state_t;
    typedef struct packed {
        logic [5:0] note;
        logic [7:0] dur;
    } entry_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_clr;
    logic             tick;
    logic [5:0]       live_note;
    logic [5:0]       key_enc_q, key_enc_d;
    logic [5:0]       run_note_q, run_note_d;
    logic [7:0]       run_dur_q, run_dur_d;
    logic [7:0]       dur_inc;
    logic [LEN_W-1:0] length_q, length_d;
    logic             full_q, full_d;
    logic [ADDR_W-1:0] play_ptr_q, play_ptr_d;
    logic [7:0]       play_left_q, play_left_d;

    // storage
    entry_t           mem [DEPTH];
    entry_t           rd_data;
    entry_t           wd;
    logic             we;
    logic [ADDR_W-1:0] wa, ra;

    // playback successor indices (wrap at length)
    logic [LEN_W-1:0]  p1, p2;
    logic              last;
    logic [ADDR_W-1:0] nxt, nxt2;

    assign live_note = (bus.key_valid && bus.key_in <= 6'd47) ? bus.key_in : REST;
    assign tick      = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign dur_inc   = run_dur_q + 8'd1;

    assign p1   = {1'b0, play_ptr_q} + LEN_W'(1);
    assign last = (p1 >= length_q);
    assign nxt  = last ? '0 : p1[ADDR_W-1:0];
    assign p2   = {1'b0, nxt} + LEN_W'(1);
    assign nxt2 = (p2 >= length_q) ? '0 : p2[ADDR_W-1:0];

    // The write address is the entry count, so clearing length also clears the
    // write pointer.
    assign wa = length_q[ADDR_W-1:0];

    always_comb begin
        state_d     = state_q;
        key_enc_d   = key_enc_q;
        run_note_d  = run_note_q;
        run_dur_d   = run_dur_q;
        length_d    = length_q;
        full_d      = full_q;
        play_ptr_d  = play_ptr_q;
        play_left_d = play_left_q;
        cnt_clr     = 1'b0;
        we          = 1'b0;
        wd          = {run_note_q, run_dur_q};
        ra          = '0;

        case (state_q)
            S_IDLE: begin
                key_enc_d = live_note;
                if (bus.stop) begin
                    // stop has priority, so it swallows any same-cycle start
                end else if (bus.rec_start) begin
                    state_d    = S_REC;
                    length_d   = '0;
                    full_d     = 1'b0;
                    run_note_d = live_note;
                    run_dur_d  = 8'd0;
                    cnt_clr    = 1'b1;
                end else if (bus.play_start && length_q != '0) begin
                    // While idle, rd_data tracks entry 0. It is loaded directly,
                    // and entry 1 is fetched so that it is ready for the first
                    // advance.
                    state_d     = S_PLAY;
                    cnt_clr     = 1'b1;
                    key_enc_d   = rd_data.note;
                    play_left_d = rd_data.dur;
                    play_ptr_d  = '0;
                    ra          = (length_q > LEN_W'(1)) ? ADDR_W'(1) : '0;
                end
            end

            S_REC: begin
                key_enc_d = live_note;
                if (bus.stop) begin
                    if (run_dur_q != 8'd0 && length_q < LEN_W'(DEPTH)) begin
                        we       = 1'b1;
                        wd       = {run_note_q, run_dur_q};
                        length_d = length_q + LEN_W'(1);
                        if (length_q == LEN_W'(DEPTH - 1)) full_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (live_note != run_note_q || dur_inc == 8'd255) begin
                        we         = 1'b1;
                        wd         = {run_note_q, dur_inc};
                        length_d   = length_q + LEN_W'(1);
                        run_note_d = live_note;
                        run_dur_d  = 8'd0;
                        if (length_q == LEN_W'(DEPTH - 1)) begin
                            full_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        run_dur_d = dur_inc;
                    end
                end
            end

            S_PLAY: begin
                // rd_data always holds the successor of the current entry.
                ra = nxt;
                if (bus.stop) begin
                    key_enc_d = REST;
                    state_d   = S_IDLE;
                end else if (tick) begin
                    if (play_left_q > 8'd1) begin
                        play_left_d = play_left_q - 8'd1;
`ifdef NOTE_REC_LOOP_EN
                    end else begin
`else
                    end else if (last) begin
                        key_enc_d = REST;
                        state_d   = S_IDLE;
                    end else begin
`endif
                        key_enc_d   = rd_data.note;
                        play_left_d = rd_data.dur;
                        play_ptr_d  = nxt;
                        ra          = nxt2;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Synchronous storage. Write-through keeps rd_data coherent when the entry
    // being prefetched is written on the same edge.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_data <= (we && wa == ra) ? wd : mem[ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_enc_q   <= REST;
            run_note_q  <= REST;
            run_dur_q   <= 8'd0;
            length_q    <= '0;
            full_q      <= 1'b0;
            play_ptr_q  <= '0;
            play_left_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= (cnt_clr || tick) ? '0 : cnt_q + CNT_W'(1);
            key_enc_q   <= key_enc_d;
            run_note_q  <= run_note_d;
            run_dur_q   <= run_dur_d;
            length_q    <= length_d;
            full_q      <= full_d;
            play_ptr_q  <= play_ptr_d;
            play_left_q <= play_left_d;
        end
    end

    assign bus.key_encoded = key_enc_q;
    assign bus.state       = state_q;
    assign bus.full        = full_q;
    assign bus.length      = length_q;
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: this is the self-checking bench for note_recorder with
// DEPTH=4 and TICK_DIV=4.
// The expected key_encoded values go into a queue when the stimulus is driven.
// They are popped one per cycle as the DUT produces its output.
module tb_note_recorder;
    localparam int DEPTH = 4;
    localparam int TICK  = 4;

    logic clk;
    logic rst_n;

    note_recorder_if #(.DEPTH(DEPTH)) bif ();

    note_recorder #(.DEPTH(DEPTH), .TICK_DIV(TICK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [5:0] exp_q [$];

    // expected recording contents for the playback trace
    int e_n;
    int e_note [4];
    int e_dur  [4];

    typedef struct {
        logic       kv;
        logic [5:0] kin;
        logic [5:0] exp_key;
    } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic kv, input logic [5:0] k, input int n);
        bif.key_valid = kv;
        bif.key_in    = k;
        repeat (n) cycle();
    endtask

    // Play the current recording and compare key_encoded on every cycle
    // against the trace that the bench expands from e_note/e_dur.
    task automatic play_check();
        int reps;
        logic [5:0] v;
`ifdef NOTE_REC_LOOP_EN
        reps = 2;
`else
        reps = 1;
`endif
        bif.key_valid  = 1'b0;
        bif.play_start = 1'b1;
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < e_n; i++)
                for (int c = 0; c < e_dur[i] * TICK; c++)
                    exp_q.push_back(6'(e_note[i]));
        cycle();
        bif.play_start = 1'b0;
        chk("play_state", int'(bif.state), 2);
        while (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            chk("play_key", int'(bif.key_encoded), int'(v));
`ifdef NOTE_REC_LOOP_EN
            if (exp_q.size() == 0) bif.stop = 1'b1;
`endif
            cycle();
        end
        bif.stop = 1'b0;
        chk("play_end_key", int'(bif.key_encoded), 63);
        chk("play_end_state", int'(bif.state), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] v;
        vt[0] = '{1'b1, 6'd0,  6'd0};
        vt[1] = '{1'b1, 6'd9,  6'd9};
        vt[2] = '{1'b1, 6'd47, 6'd47};
        vt[3] = '{1'b1, 6'd48, 6'd63};
        vt[4] = '{1'b1, 6'd63, 6'd63};
        vt[5] = '{1'b0, 6'd9,  6'd63};
        vt[6] = '{1'b1, 6'd20, 6'd20};
        vt[7] = '{1'b0, 6'd0,  6'd63};

        rst_n = 1'b0;
        bif.key_valid  = 1'b0;
        bif.key_in     = 6'd0;
        bif.rec_start  = 1'b0;
        bif.play_start = 1'b0;
        bif.stop       = 1'b0;
        cycle();
        cycle();
        chk("rst_key", int'(bif.key_encoded), 63);
        chk("rst_state", int'(bif.state), 0);
        chk("rst_full", int'(bif.full), 0);
        chk("rst_length", int'(bif.length), 0);
        rst_n = 1'b1;
        cycle();

        // live note passthrough in IDLE with one cycle of latency
        foreach (vt[i]) begin
            bif.key_valid = vt[i].kv;
            bif.key_in    = vt[i].kin;
            exp_q.push_back(vt[i].exp_key);
            cycle();
            v = exp_q.pop_front();
            chk("idle_key", int'(bif.key_encoded), int'(v));
        end
        chk("idle_state", int'(bif.state), 0);

        // Record hold: 10 ticks of key 9, then 3 ticks of rest, then stop.
        bif.rec_start = 1'b1;
        hold(1'b1, 6'd9, 1);
        bif.rec_start = 1'b0;
        chk("rec_state", int'(bif.state), 1);
        chk("rec_length0", int'(bif.length), 0);
        hold(1'b1, 6'd9, 39);
        hold(1'b0, 6'd0, 13);
        bif.stop = 1'b1;
        cycle();
        bif.stop = 1'b0;
        chk("rec_stop_state", int'(bif.state), 0);
        chk("rec_length", int'(bif.length), 2);
        chk("rec_full", int'(bif.full), 0);

        e_n = 2;
        e_note[0] = 9;  e_dur[0] = 10;
        e_note[1] = 63; e_dur[1] = 3;
        play_check();
        chk("play_length_kept", int'(bif.length), 2);

        // Priority: stop, rec_start and play_start pulsed together in PLAY
        bif.play_start = 1'b1;
        cycle();
        bif.play_start = 1'b0;
        repeat (4) cycle();
        chk("prio_pre_key", int'(bif.key_encoded), 9);
        bif.stop = 1'b1; bif.rec_start = 1'b1; bif.play_start = 1'b1;
        cycle();
        bif.stop = 1'b0; bif.rec_start = 1'b0; bif.play_start = 1'b0;
        chk("prio_state", int'(bif.state), 0);
        chk("prio_key", int'(bif.key_encoded), 63);
        chk("prio_length", int'(bif.length), 2);
        cycle();
        chk("prio_state2", int'(bif.state), 0);

        // Reset asserted mid-PLAY aborts asynchronously
        bif.play_start = 1'b1;
        cycle();
        bif.play_start = 1'b0;
        repeat (3) cycle();
        chk("rst_play_state", int'(bif.state), 2);
        rst_n = 1'b0;
        #1;
        chk("arst_key", int'(bif.key_encoded), 63);
        chk("arst_state", int'(bif.state), 0);
        chk("arst_length", int'(bif.length), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Saturation: key 5 for 300 ticks yields {5,255},{5,45}
        bif.rec_start = 1'b1;
        hold(1'b1, 6'd5, 1);
        bif.rec_start = 1'b0;
        hold(1'b1, 6'd5, 1200);
        bif.stop = 1'b1;
        cycle();
        bif.stop = 1'b0;
        chk("sat_length", int'(bif.length), 2);
        chk("sat_full", int'(bif.full), 0);
        e_n = 2;
        e_note[0] = 5; e_dur[0] = 255;
        e_note[1] = 5; e_dur[1] = 45;
        play_check();

        // Overflow: notes 1,2,1,2,1 for one tick each. The 4th write fills the
        // store.
        bif.rec_start = 1'b1;
        hold(1'b1, 6'd1, 1);
        bif.rec_start = 1'b0;
        hold(1'b1, 6'd1, 3);
        hold(1'b1, 6'd2, 4);
        hold(1'b1, 6'd1, 4);
        hold(1'b1, 6'd2, 4);
        chk("ovf_pre_state", int'(bif.state), 1);
        chk("ovf_pre_length", int'(bif.length), 3);
        hold(1'b1, 6'd1, 1);
        chk("ovf_full", int'(bif.full), 1);
        chk("ovf_length", int'(bif.length), 4);
        chk("ovf_state", int'(bif.state), 0);
        hold(1'b1, 6'd1, 8);
        chk("ovf_no_write", int'(bif.length), 4);
        e_n = 4;
        e_note[0] = 1; e_dur[0] = 1;
        e_note[1] = 2; e_dur[1] = 1;
        e_note[2] = 1; e_dur[2] = 1;
        e_note[3] = 2; e_dur[3] = 1;
        play_check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/note_recorder.md
NOTE_RECORDER -- requirements
Module: note_recorder

Interface
REQ-001 Parameter DEPTH, default 64, is the number of stored note entries; the implementation SHALL support a power of two from 4 to 256.
REQ-002 Parameter TICK_DIV, default 500000, is the number of clk cycles per duration tick (10 ms at 50 MHz); legal range is 2 or more.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-005 key_valid  input  1  means a key is currently held.
REQ-006 key_in  input  6  is the held key code, 0..47; it is meaningful only while key_valid=1.
REQ-007 rec_start, play_start, stop  input  1 each  are single-cycle command pulses.
REQ-008 key_encoded  output  6  is the note code to the key decoder; code 63 means rest (silence).
REQ-009 state  output  2  reports the mode: 0=IDLE, 1=REC, 2=PLAY.
REQ-010 full  output  1  means the last recording was cut off at DEPTH entries.
REQ-011 length  output  log2(DEPTH)+1  is the number of stored entries.

Function
REQ-012 The live note SHALL be key_in when key_valid=1 and key_in<=47, and 63 otherwise.
REQ-013 key_encoded SHALL be a register; in IDLE and REC it SHALL equal the live note with 1-cycle latency.
REQ-014 A tick counter SHALL count 0..TICK_DIV-1, wrap, and clear to 0 on every entry to REC or PLAY; a tick is the cycle in which it wraps.
REQ-015 Commands SHALL have priority stop > rec_start > play_start when pulsed in the same cycle.
REQ-016 rec_start and play_start SHALL be accepted only in IDLE; in REC or PLAY they SHALL be ignored.
REQ-017 rec_start SHALL have this effect: length<=0, full<=0, write pointer<=0, run note<=live note, run duration<=0, state<=REC.
REQ-018 Each stored entry SHALL be {note[5:0], dur[7:0]} with dur in 1..255, held in DEPTH-entry synchronous storage.
REQ-019 On each tick in REC, with d=dur+1: if live note differs from the run note or d==255, the block SHALL write {run note,d}, start a new run {live note,0}, and increment length; otherwise it SHALL set dur<=d.
REQ-020 stop in REC SHALL write the pending run if dur>0 and space remains, then go to IDLE.
REQ-021 When a write fills entry DEPTH-1 in REC, the block SHALL set full<=1 and go to IDLE in the same cycle; no further writes SHALL occur.
REQ-022 play_start with length==0 SHALL be ignored.
REQ-023 In PLAY, entry i SHALL drive key_encoded for exactly dur_i ticks, starting at entry 0 from the PLAY entry cycle; read latency SHALL be hidden so there are no gap cycles between entries.
REQ-024 After the last entry expires, the block SHALL set key_encoded<=63 and state<=IDLE.
REQ-025 stop in PLAY SHALL force key_encoded<=63 and state<=IDLE on the next edge.
REQ-026 Stored contents and length SHALL be retained across IDLE and PLAY until the next rec_start.

Reset
REQ-027 While rst_n=0, the block SHALL hold state=IDLE, key_encoded=63, full=0, length=0, all pointers and counters 0; storage contents are don't-care.
REQ-028 Reset asserted during REC or PLAY SHALL abort immediately with no final write.

Configuration
REQ-029 With NOTE_REC_LOOP_EN defined, PLAY SHALL restart at entry 0 after the last entry, with no gap, until stop is pulsed.
REQ-030 Without NOTE_REC_LOOP_EN, PLAY SHALL run once as in REQ-024.

Verification (TICK_DIV=4, DEPTH=4)
REQ-031 Record hold: rec_start; key 9 held 10 ticks; key released 3 ticks; stop -> entries {9,10},{63,3}; length=2.
REQ-032 Playback: after REQ-031, play_start -> key_encoded=9 for 40 cycles, then 63 for 12 cycles, then state=IDLE and key_encoded=63.
REQ-033 Saturation: key 5 held 300 ticks, then stop -> entries {5,255},{5,45}.
REQ-034 Overflow: 5 alternating notes, 1 tick each -> full=1, length=4, state=IDLE after the 4th write.
REQ-035 Priority: stop, rec_start and play_start pulsed together in PLAY -> IDLE, key_encoded=63, length unchanged.
REQ-036 Reset: rst_n low mid-PLAY -> key_encoded=63, state=0, length=0 asynchronously; with NOTE_REC_LOOP_EN defined, replay of REQ-031 wraps 9->63->9 with no gap.
